// File: rtl/slow_clock_gen.sv
// slow_clock_gen: programmable clock divider producing a registered square-wave
// timebase (slow_clk) from clk by counting a programmable half-period.
// Optional macro SLOW_CLOCK_TICK_EN builds the one-cycle 'tick' pulse on each
// rising slow_clk; without it, tick is tied to 0 and no tick register exists.
`timescale 1ns/1ps

module slow_clock_gen #(
  parameter int CNT_W        = 26,
  parameter int HALF_DEFAULT = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             half_load,
  input  logic [CNT_W-1:0] half_val,
  output logic             slow_clk,
  output logic             tick
);

  localparam logic [CNT_W-1:0] HALF_INIT = CNT_W'(HALF_DEFAULT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             slow_clk_q, slow_clk_d;
  logic             wrap;

  // Terminal count: cnt never exceeds half_q-1 because a load always zeroes it.
  assign wrap = (cnt_q == half_q - ONE);

  // Next-state: load has priority over count; with neither, everything holds.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    half_d     = half_q;
    cnt_d      = cnt_q;
    slow_clk_d = slow_clk_q;
    if (half_load) begin
      half_d = (half_val == '0) ? ONE : half_val;
      cnt_d  = '0;
    end else if (en) begin
      if (wrap) begin
        cnt_d      = '0;
        slow_clk_d = ~slow_clk_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      half_q     <= HALF_INIT;
      cnt_q      <= '0;
      slow_clk_q <= 1'b0;
    end else begin
      half_q     <= half_d;
      cnt_q      <= cnt_d;
      slow_clk_q <= slow_clk_d;
    end
  end

  assign slow_clk = slow_clk_q;

`ifdef SLOW_CLOCK_TICK_EN
  logic tick_q, tick_d;

  // Tick fires on the edge that toggles slow_clk from 0 to 1.
  always_comb begin
    tick_d = !half_load && en && wrap && !slow_clk_q;
  end

  // Tick register, high for exactly the first cycle slow_clk reads 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= tick_d;
  end

  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

endmodule

// File: tb/tb_slow_clock_gen.sv
// tb_slow_clock_gen: directed self-checking bench for slow_clock_gen with
// HALF_DEFAULT=4 and a 2 ns clk. Expected tick depends on SLOW_CLOCK_TICK_EN.
`timescale 1ns/1ps

module tb_slow_clock_gen;

  localparam int CNT_W = 26;
`ifdef SLOW_CLOCK_TICK_EN
  localparam bit TICK_ON = 1'b1;
`else
  localparam bit TICK_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             half_load;
  logic [CNT_W-1:0] half_val;
  logic             slow_clk;
  logic             tick;

  int total = 0;
  int bad   = 0;
  int tick_seen = 0;

  slow_clock_gen #(.CNT_W(CNT_W), .HALF_DEFAULT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .half_load (half_load),
    .half_val  (half_val),
    .slow_clk  (slow_clk),
    .tick      (tick)
  );

  always #1 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clk edge, sampled 0.5 ns later; checks slow_clk and tick.
  task automatic cyc(input string tag, input logic exp_slow, input logic exp_tick);
    @(posedge clk);
    #0.5;
    if (tick === 1'b1) tick_seen++;
    check({tag, "_slow"}, {31'd0, slow_clk}, {31'd0, exp_slow});
    check({tag, "_tick"}, {31'd0, tick},     {31'd0, exp_tick});
  endtask

  // len edges during which slow_clk reads 'level'; tick expected on the
  // first edge of a high phase when 'fresh' (the edge that toggled it high).
  task automatic phase(input string tag, input logic level, input int len, input bit fresh);
    for (int i = 0; i < len; i++)
      cyc(tag, level, TICK_ON && level && fresh && (i == 0));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; half_load = 1'b0; half_val = '0;

    // Reset held for 10 cycles: outputs low throughout.
    phase("rst", 1'b0, 10, 1'b0);

    // Release with en=1: first rise on the 4th edge, then 4 high / 4 low.
    rst_n = 1'b1; en = 1'b1;
    phase("rel_lo", 1'b0, 3, 1'b0);
    phase("rel_hi", 1'b1, 4, 1'b1);
    phase("p1_lo",  1'b0, 4, 1'b0);
    phase("p1_hi",  1'b1, 4, 1'b1);

    // Enable stall of 3 cycles in a low phase: the phase lasts 7 cycles.
    phase("st_lo_a", 1'b0, 2, 1'b0);
    en = 1'b0;
    phase("st_lo_frz", 1'b0, 3, 1'b0);
    en = 1'b1;
    phase("st_lo_b", 1'b0, 2, 1'b0);

    // Stall in a high phase: slow_clk holds high, tick stays 0.
    phase("st_hi_a", 1'b1, 1, 1'b1);
    en = 1'b0;
    phase("st_hi_frz", 1'b1, 3, 1'b0);
    en = 1'b1;
    phase("st_hi_b", 1'b1, 3, 1'b0);

    // Load half_val=2 one cycle into a low phase: no toggle on the load edge,
    // next toggle 2 edges after it, then period 4.
    phase("ld2_pre", 1'b0, 1, 1'b0);
    half_load = 1'b1; half_val = 26'd2;
    cyc("ld2_edge", 1'b0, 1'b0);
    half_load = 1'b0;
    phase("ld2_lo", 1'b0, 1, 1'b0);
    phase("ld2_hi", 1'b1, 2, 1'b1);
    phase("ld2_lo2", 1'b0, 2, 1'b0);
    phase("ld2_hi2", 1'b1, 2, 1'b1);

    // Load half_val=0 (treated as 1): hold on load edge, then toggle every edge.
    half_load = 1'b1; half_val = '0;
    cyc("ld0_edge", 1'b1, 1'b0);
    half_load = 1'b0;
    phase("ld0_a", 1'b0, 1, 1'b0);
    phase("ld0_b", 1'b1, 1, 1'b1);
    phase("ld0_c", 1'b0, 1, 1'b0);
    phase("ld0_d", 1'b1, 1, 1'b1);

    // Load 3, run to cnt==2 in a low phase, then collide a reload with the wrap.
    half_load = 1'b1; half_val = 26'd3;
    cyc("ld3_edge", 1'b1, 1'b0);
    half_load = 1'b0;
    phase("ld3_hi", 1'b1, 2, 1'b0);
    phase("ld3_lo", 1'b0, 3, 1'b0);
    half_load = 1'b1; half_val = 26'd3;
    cyc("col_edge", 1'b0, 1'b0);
    half_load = 1'b0;
    phase("col_lo", 1'b0, 2, 1'b0);
    phase("col_hi", 1'b1, 3, 1'b1);

    // Async reset mid-high-phase: clears before the next edge, half back to 4.
    phase("ar_lo", 1'b0, 3, 1'b0);
    phase("ar_hi", 1'b1, 1, 1'b1);
    rst_n = 1'b0;
    #0.2;
    check("async_slow", {31'd0, slow_clk}, 32'd0);
    check("async_tick", {31'd0, tick},     32'd0);
    phase("ar_hold", 1'b0, 2, 1'b0);
    rst_n = 1'b1;
    phase("ar_rel_lo", 1'b0, 3, 1'b0);
    phase("ar_rel_hi", 1'b1, 4, 1'b1);

    // Five full periods: exactly five tick pulses when the feature is built.
    tick_seen = 0;
    for (int p = 0; p < 5; p++) begin
      phase("tk_lo", 1'b0, 4, 1'b0);
      phase("tk_hi", 1'b1, 4, 1'b1);
    end
    check("tick_count", tick_seen, TICK_ON ? 32'd5 : 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slow_clock_gen.md
Name: slow_clock_gen

Overview:
- Programmable clock divider: derives a slow square-wave enable-clock (slow_clk) from the system clock by counting a programmable half-period.
- Feeds game-tick and display-refresh logic that needs a low-rate timebase, e.g. about 1 Hz from 100 MHz.
- Fully synchronous to clk except for the asynchronous reset.
- slow_clk is a registered output and is intended as a logic timebase, not a global clock.

Parameters:
- CNT_W, 26, width of the counter and of half_val.
- HALF_DEFAULT, 50_000_000, half-period in clk cycles loaded at reset. It must be ≥1 and must fit in CNT_W bits.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset, asynchronous assert, active-low.
- en  input  1  count enable; when low, counter and outputs hold.
- half_load  input  1  one-cycle strobe that loads a new half-period from half_val.
- half_val  input  CNT_W  new half-period in clk cycles; 0 is treated as 1.
- slow_clk  output  1  divided square wave, registered.
- tick  output  1  one-cycle pulse on each 0→1 transition of slow_clk; see Optional Feature.

Interface note: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Internal registers: half_reg (CNT_W), cnt (CNT_W), slow_clk, tick.
- Reset state while rst_n=0, taking effect immediately with no clk edge needed: half_reg=HALF_DEFAULT, cnt=0, slow_clk=0, tick=0.
- Priority on each rising clk edge is load, then count, then hold.
- Load (half_load=1):
  - half_reg <= (half_val==0 ? 1 : half_val).
  - cnt <= 0.
  - slow_clk is unchanged and there is no toggle that cycle, even if en=1.
- Count (half_load=0, en=1):
  - If cnt == half_reg−1: cnt <= 0 and slow_clk <= ~slow_clk.
  - Otherwise: cnt <= cnt+1.
- Hold (half_load=0, en=0): cnt and slow_clk keep their values.
- Timing:
  - After reset release with en held high, the first slow_clk rise occurs on the half_reg-th rising clk edge.
  - The steady-state period is 2·half_reg enabled clk cycles with a 50% duty cycle.
  - half_reg=1 gives slow_clk = clk/2, toggling on every enabled edge.
- A new half-period takes effect from the cycle after the load. Because cnt is zeroed on load, the counter cannot overrun when half_reg shrinks below the current cnt.
- Counter arithmetic is unsigned CNT_W-bit. Because of the compare, cnt never exceeds half_reg−1, so no wrap-around occurs.
- tick (when enabled): registered and asserted for exactly one clk cycle, in the same cycle slow_clk first reads 1 after a 0→1 toggle. It is 0 in every other cycle, including when en holds slow_clk high.
- Reset asserted mid-operation clears everything immediately. Counting restarts from cnt=0 on the first edge after release.
- There is no combinational path from any input to any output.

Optional Feature:
- Macro SLOW_CLOCK_TICK_EN.
- Defined: tick is generated as described in Behaviour.
- Not defined: tick is tied to constant 0 and its register is not built. The port remains present so the interface does not change.
- slow_clk behaviour is identical in both builds.

Test Plan:
- Bench setup: HALF_DEFAULT overridden to 4, clk period 2 ns.
- Reset/default: hold rst_n=0 for 10 cycles, then release with en=1 → slow_clk=0 and tick=0 during reset; first slow_clk rise on the 4th clk edge after release; period 8 clk cycles (16 ns) with 4 high / 4 low.
- Enable stall: drop en for 3 cycles midway through a low phase → that phase lasts 7 cycles instead of 4; cnt and slow_clk frozen while en=0.
- Load: pulse half_load with half_val=2 → next toggle 2 cycles after the load, then period 4 cycles. Pulse with half_val=0 → slow_clk toggles every cycle (period 2).
- Load and count collision: assert half_load in the same cycle cnt==half_reg−1 with en=1 → no toggle that cycle; cnt=0; next toggle half_reg cycles later.
- Async reset: drive rst_n low mid-cycle while slow_clk=1 → slow_clk=0 before the next clk edge; half_reg returns to 4 even after an earlier load of 2.
- Tick: over 5 slow_clk periods with SLOW_CLOCK_TICK_EN defined → exactly 5 single-cycle tick pulses, each coincident with the first cycle slow_clk=1. With the macro undefined → tick constant 0.
